// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares one I2C_Driver between two requesters: requester 0 is the altimeter
// controller and requester 1 is the IMU controller. Both sensors sit on a
// common SDA/SCL pair.
//
// Arbitration rules:
//   - Grants are issued round-robin.
//   - A grant is held for a whole (multi-byte) transaction, until the holder
//     drops its request.
//   - After a release, the arbiter waits in RELEASE until the driver reports
//     idle (busy low, ready high). Only then can a new grant be issued.
//
// Optional feature, enabled by defining the macro I2C_BUS_ARBITER_TIMEOUT_EN:
//   - A watchdog revokes a grant that has been held for TIMEOUT_CYCLES
//     cycles.
//   - It then locks the offending requester out until that requester drops
//     its request.
//   Without the macro, a grant is held indefinitely and timeout is tied low.
//
// Parameters
//   TIMEOUT_CYCLES  maximum grant hold in clk cycles (watchdog build only)
//   CTR_SIZE        watchdog counter width, 2**CTR_SIZE > TIMEOUT_CYCLES
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req0/req1                      requests, high for the whole transaction
//   gnt0/gnt1                      registered grants
//   ena*/rw*/start_transfer*/
//   stop_transfer*/r_start*/
//   data_wr*                       per-requester driver commands
//   data_rd*/busy*/ready*/ack_err* per-requester view of driver status
//   drv_*                          muxed commands to / status from driver
//   timeout                        one-cycle pulse when a grant is revoked
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd2000000,
  parameter int unsigned CTR_SIZE       = 32'd21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       ena0,
  input  logic       rw0,
  input  logic       start_transfer0,
  input  logic       stop_transfer0,
  input  logic       r_start0,
  input  logic       ena1,
  input  logic       rw1,
  input  logic       start_transfer1,
  input  logic       stop_transfer1,
  input  logic       r_start1,
  input  logic [7:0] data_wr0,
  input  logic [7:0] data_wr1,
  output logic [7:0] data_rd0,
  output logic [7:0] data_rd1,
  output logic       busy0,
  output logic       busy1,
  output logic       ready0,
  output logic       ready1,
  output logic       ack_err0,
  output logic       ack_err1,
  output logic       drv_ena,
  output logic       drv_rw,
  output logic       drv_start_transfer,
  output logic       drv_stop_transfer,
  output logic       drv_r_start,
  output logic [7:0] drv_data_wr,
  input  logic [7:0] drv_data_rd,
  input  logic       drv_busy,
  input  logic       drv_ready,
  input  logic       drv_ack_err,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT0  = 2'd1,
    ST_GRANT1  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Reject a watchdog counter too narrow to reach the timeout value.
  if ((TIMEOUT_CYCLES == 32'd0) ||
      ((CTR_SIZE < 32'd32) && ((32'd1 << CTR_SIZE) <= TIMEOUT_CYCLES))) begin : g_bad_cfg
    $error("i2c_bus_arbiter: CTR_SIZE too small for TIMEOUT_CYCLES");
  end

  state_e state_q;
  logic   last_q;     // requester that held the most recent grant
  logic   gnt0_q;
  logic   gnt1_q;
  logic   timeout_q;
  logic   elig0_s;    // request that may be granted from IDLE
  logic   elig1_s;

`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
  localparam logic [CTR_SIZE-1:0] TIMEOUT_LAST = CTR_SIZE'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CTR_SIZE-1:0] CTR_ONE      = {{(CTR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CTR_SIZE-1:0] CTR_ZERO     = {CTR_SIZE{1'b0}};

  logic [CTR_SIZE-1:0] ctr_q;
  logic                lock0_q;   // set by a watchdog revoke, cleared by req low
  logic                lock1_q;

  assign elig0_s = req0 & ~lock0_q;
  assign elig1_s = req1 & ~lock1_q;
`else
  assign elig0_s = req0;
  assign elig1_s = req1;
`endif

  // Arbitration FSM with registered grants, timeout pulse and watchdog state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
      ctr_q     <= CTR_ZERO;
      lock0_q   <= 1'b0;
      lock1_q   <= 1'b0;
`endif
    end else begin
      timeout_q <= 1'b0;
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
      // A lockout ends as soon as the requester is seen low, in any state.
      if (!req0) lock0_q <= 1'b0;
      else       lock0_q <= lock0_q;
      if (!req1) lock1_q <= 1'b0;
      else       lock1_q <= lock1_q;
`endif
      case (state_q)
        ST_IDLE: begin
          // Requester 0 wins outright, or on a tie when requester 1 went last.
          if (elig0_s && (!elig1_s || last_q)) begin
            state_q <= ST_GRANT0;
            gnt0_q  <= 1'b1;
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
            ctr_q   <= CTR_ZERO;
`endif
          end else if (elig1_s) begin
            state_q <= ST_GRANT1;
            gnt1_q  <= 1'b1;
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
            ctr_q   <= CTR_ZERO;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT0: begin
          if (!req0) begin
            state_q <= ST_RELEASE;
            gnt0_q  <= 1'b0;
            last_q  <= 1'b0;
          end
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
          else if (ctr_q == TIMEOUT_LAST) begin
            state_q   <= ST_RELEASE;
            gnt0_q    <= 1'b0;
            last_q    <= 1'b0;
            timeout_q <= 1'b1;
            lock0_q   <= 1'b1;
          end else begin
            ctr_q <= ctr_q + CTR_ONE;
          end
`else
          else begin
            state_q <= ST_GRANT0;
          end
`endif
        end
        ST_GRANT1: begin
          if (!req1) begin
            state_q <= ST_RELEASE;
            gnt1_q  <= 1'b0;
            last_q  <= 1'b1;
          end
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
          else if (ctr_q == TIMEOUT_LAST) begin
            state_q   <= ST_RELEASE;
            gnt1_q    <= 1'b0;
            last_q    <= 1'b1;
            timeout_q <= 1'b1;
            lock1_q   <= 1'b1;
          end else begin
            ctr_q <= ctr_q + CTR_ONE;
          end
`else
          else begin
            state_q <= ST_GRANT1;
          end
`endif
        end
        ST_RELEASE: begin
          // Let the driver finish the tail of the last transfer before re-arbitrating.
          if (!drv_busy && drv_ready) state_q <= ST_IDLE;
          else                        state_q <= ST_RELEASE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign timeout = timeout_q;

  // Command mux to the driver and status routing back to the grant holder only.
  always_comb begin
    drv_ena            = 1'b0;
    drv_rw             = 1'b0;
    drv_start_transfer = 1'b0;
    drv_stop_transfer  = 1'b0;
    drv_r_start        = 1'b0;
    drv_data_wr        = 8'h00;
    data_rd0           = 8'h00;
    data_rd1           = 8'h00;
    busy0              = 1'b1;
    busy1              = 1'b1;
    ready0             = 1'b0;
    ready1             = 1'b0;
    ack_err0           = 1'b0;
    ack_err1           = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        drv_ena            = ena0;
        drv_rw             = rw0;
        drv_start_transfer = start_transfer0;
        drv_stop_transfer  = stop_transfer0;
        drv_r_start        = r_start0;
        drv_data_wr        = data_wr0;
        data_rd0           = drv_data_rd;
        busy0              = drv_busy;
        ready0             = drv_ready;
        ack_err0           = drv_ack_err;
      end
      ST_GRANT1: begin
        drv_ena            = ena1;
        drv_rw             = rw1;
        drv_start_transfer = start_transfer1;
        drv_stop_transfer  = stop_transfer1;
        drv_r_start        = r_start1;
        drv_data_wr        = data_wr1;
        data_rd1           = drv_data_rd;
        busy1              = drv_busy;
        ready1             = drv_ready;
        ack_err1           = drv_ack_err;
      end
      default: begin
        drv_ena = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter. The expected grant owners are queued
// when requests are raised and popped when a grant appears.
module tb_i2c_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, gnt0, gnt1;
  logic       ena0, rw0, start_transfer0, stop_transfer0, r_start0;
  logic       ena1, rw1, start_transfer1, stop_transfer1, r_start1;
  logic [7:0] data_wr0, data_wr1, data_rd0, data_rd1;
  logic       busy0, busy1, ready0, ready1, ack_err0, ack_err1;
  logic       drv_ena, drv_rw, drv_start_transfer, drv_stop_transfer, drv_r_start;
  logic [7:0] drv_data_wr, drv_data_rd;
  logic       drv_busy, drv_ready, drv_ack_err, timeout;

  int   checks = 0;
  int   errors = 0;
  int   sb_q[$];
  logic both_high_r = 1'b0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.TIMEOUT_CYCLES(16), .CTR_SIZE(5)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .ena0(ena0), .rw0(rw0), .start_transfer0(start_transfer0),
    .stop_transfer0(stop_transfer0), .r_start0(r_start0),
    .ena1(ena1), .rw1(rw1), .start_transfer1(start_transfer1),
    .stop_transfer1(stop_transfer1), .r_start1(r_start1),
    .data_wr0(data_wr0), .data_wr1(data_wr1), .data_rd0(data_rd0), .data_rd1(data_rd1),
    .busy0(busy0), .busy1(busy1), .ready0(ready0), .ready1(ready1),
    .ack_err0(ack_err0), .ack_err1(ack_err1),
    .drv_ena(drv_ena), .drv_rw(drv_rw), .drv_start_transfer(drv_start_transfer),
    .drv_stop_transfer(drv_stop_transfer), .drv_r_start(drv_r_start),
    .drv_data_wr(drv_data_wr), .drv_data_rd(drv_data_rd),
    .drv_busy(drv_busy), .drv_ready(drv_ready), .drv_ack_err(drv_ack_err),
    .timeout(timeout)
  );

  // Sticky flag: both grants must never be high together.
  always @(negedge clk) begin
    if (gnt0 && gnt1) both_high_r <= 1'b1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant, then compare its owner with the scoreboard head.
  task automatic grant_next(input int bound, output int lat, output int who);
    int  exp;
    bit  seen;
    seen = 1'b0;
    who  = -1;
    lat  = 0;
    while (!seen && lat < bound) begin
      tick();
      lat++;
      if (gnt0 || gnt1) begin
        seen = 1'b1;
        who  = gnt0 ? 0 : 1;
      end
    end
    if (!seen) lat = -1;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    else                 exp = -2;
    check("grant_owner", who, exp);
  endtask

  initial begin
    int lat, who, held;
    bit bad;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
    ena0 = 1'b0; rw0 = 1'b0; start_transfer0 = 1'b0; stop_transfer0 = 1'b0; r_start0 = 1'b0;
    ena1 = 1'b0; rw1 = 1'b0; start_transfer1 = 1'b0; stop_transfer1 = 1'b0; r_start1 = 1'b0;
    data_wr0 = 8'h00; data_wr1 = 8'h00;
    drv_data_rd = 8'hA5; drv_busy = 1'b0; drv_ready = 1'b1; drv_ack_err = 1'b1;
    repeat (3) tick();

    // Reset: no grant even with req0 high, status masked.
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_busy0", busy0, 1'b1);
    check("rst_busy1", busy1, 1'b1);
    check("rst_ready0", ready0, 1'b0);
    check("rst_ack_err0", ack_err0, 1'b0);
    check("rst_data_rd0", data_rd0, 8'h00);
    check("rst_timeout", timeout, 1'b0);
    rst = 1'b0; req0 = 1'b0; drv_ack_err = 1'b0; drv_data_rd = 8'h00;
    repeat (2) tick();

    // Single requester.
    req0 = 1'b1; ena0 = 1'b1; data_wr0 = 8'hEE; ena1 = 1'b1; data_wr1 = 8'h11;
    sb_q.push_back(0);
    grant_next(8, lat, who);
    check("single_latency", lat, 1);
    drv_data_rd = 8'h33; #1;
    check("single_drv_ena", drv_ena, 1'b1);
    check("single_drv_data_wr", drv_data_wr, 8'hEE);
    check("single_busy1", busy1, 1'b1);
    check("single_ready1", ready1, 1'b0);
    check("single_busy0", busy0, 1'b0);
    check("single_ready0", ready0, 1'b1);
    check("single_data_rd0", data_rd0, 8'h33);
    check("single_data_rd1", data_rd1, 8'h00);
    tick(); req0 = 1'b0;
    tick();
    check("rel_gnt0", gnt0, 1'b0);
    check("rel_drv_ena", drv_ena, 1'b0);
    drv_data_rd = 8'h00;
    repeat (2) tick();

    // Simultaneous requests from reset: 0,1,0,1, each 3 bytes.
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(0); sb_q.push_back(1);
    for (int t = 0; t < 4; t++) begin
      grant_next(10, lat, who);
      check("rr_latency", lat, (t == 0) ? 1 : 2);
      for (int b = 0; b < 3; b++) begin
        drv_busy = 1'b1; drv_ready = 1'b0;
        tick(); tick();
        drv_busy = 1'b0; drv_ready = 1'b1;
        tick();
      end
      if (who == 0) req0 = 1'b0;
      else          req1 = 1'b0;
      tick();
      if (t < 3) begin
        req0 = 1'b1; req1 = 1'b1;
      end else begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    repeat (3) tick();

    // Holder drops req0 while the driver is still busy.
    req0 = 1'b1;
    sb_q.push_back(0);
    grant_next(8, lat, who);
    drv_busy = 1'b1; drv_ready = 1'b0;
    tick();
    req0 = 1'b0; req1 = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gnt0 || gnt1 || drv_ena) bad = 1'b1;
    end
    check("busy_tail_quiet", bad, 1'b0);
    drv_busy = 1'b0; drv_ready = 1'b1;
    sb_q.push_back(1);
    grant_next(8, lat, who);
    check("busy_tail_latency", lat, 2);

    // Status and command routing during GRANT1.
    rw1 = 1'b1; start_transfer1 = 1'b1; stop_transfer1 = 1'b0; r_start1 = 1'b0;
    rw0 = 1'b0; start_transfer0 = 1'b0; stop_transfer0 = 1'b1; r_start0 = 1'b1;
    data_wr1 = 8'h11; drv_ack_err = 1'b1; drv_data_rd = 8'h5A; #1;
    check("g1_ack_err1", ack_err1, 1'b1);
    check("g1_ack_err0", ack_err0, 1'b0);
    check("g1_data_rd1", data_rd1, 8'h5A);
    check("g1_data_rd0", data_rd0, 8'h00);
    check("g1_drv_rw", drv_rw, 1'b1);
    check("g1_drv_start", drv_start_transfer, 1'b1);
    check("g1_drv_stop", drv_stop_transfer, 1'b0);
    check("g1_drv_r_start", drv_r_start, 1'b0);
    check("g1_drv_data_wr", drv_data_wr, 8'h11);
    check("g1_busy0", busy0, 1'b1);
    tick(); req1 = 1'b0; drv_ack_err = 1'b0; drv_data_rd = 8'h00;
    repeat (3) tick();

`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
    // Watchdog: req0 stuck high.
    req0 = 1'b1;
    sb_q.push_back(0);
    grant_next(8, lat, who);
    req1 = 1'b1;
    sb_q.push_back(1);
    held = 0;
    while (gnt0 && held < 40) begin
      held++;
      tick();
    end
    check("wd_hold_cycles", held, 16);
    check("wd_pulse", timeout, 1'b1);
    check("wd_gnt0_drop", gnt0, 1'b0);
    tick();
    check("wd_pulse_once", timeout, 1'b0);
    grant_next(8, lat, who);
    tick(); req1 = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gnt0) bad = 1'b1;
    end
    check("wd_lockout", bad, 1'b0);
    req0 = 1'b0; tick(); req0 = 1'b1;
    sb_q.push_back(0);
    grant_next(8, lat, who);
    check("wd_regrant_latency", lat, 1);
    tick(); req0 = 1'b0;
    repeat (3) tick();
`else
    // No watchdog: a grant is held indefinitely.
    req0 = 1'b1;
    sb_q.push_back(0);
    grant_next(8, lat, who);
    repeat (40) tick();
    check("hold_gnt0", gnt0, 1'b1);
    check("hold_timeout", timeout, 1'b0);
    req0 = 1'b0;
    repeat (3) tick();
`endif

    // Reset in the middle of a GRANT0 transaction.
    req0 = 1'b1;
    sb_q.push_back(0);
    grant_next(8, lat, who);
    tick(); rst = 1'b1;
    tick();
    check("mid_rst_gnt0", gnt0, 1'b0);
    check("mid_rst_gnt1", gnt1, 1'b0);
    check("mid_rst_busy0", busy0, 1'b1);
    check("mid_rst_busy1", busy1, 1'b1);
    rst = 1'b0; req1 = 1'b1;
    sb_q.push_back(0);
    grant_next(8, lat, who);
    check("post_rst_latency", lat, 1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();

    check("sb_empty", sb_q.size(), 0);
    check("no_double_grant", both_high_r, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
